// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: input synchronisers, clock filter, frame deframer, byte FIFO and held output stage.
// Optional parity rejection is enabled with `define PS2_RX_PARITY_CHECK_EN.
module ps2_rx_fifo #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 4000,
    parameter int FIFO_AW     = 2,
    parameter int HOLD_CYC    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] rx_scan_code,
    output logic       rx_data_ready,
    input  logic       rx_read,
    output logic       rx_overflow,
    output logic       rx_frame_err
);
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam int HW    = $clog2(HOLD_CYC + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0] raw_in;
    logic [1:0] sync_in;
    assign raw_in = {ps2_data_i, ps2_clk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Lines idle high, so the synchroniser resets to 1 to avoid a fake edge.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_in[gi] = sync_reg;
        end
    endgenerate

    logic          clk_s;
    logic          data_s;
    assign clk_s  = sync_in[0];
    assign data_s = sync_in[1];

    logic          filt_reg;
    logic          filt_prev_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          strobe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_reg      <= 1'b1;
            filt_prev_reg <= 1'b1;
            filt_cnt_reg  <= '0;
        end else begin
            filt_prev_reg <= filt_reg;
            if (clk_s == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_reg     <= clk_s;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign strobe = filt_prev_reg & ~filt_reg;

    state_t        state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic          parity_reg;
    logic [TW-1:0] tmo_reg;
    logic          parity_ok;
    logic          good_w;

`ifdef PS2_RX_PARITY_CHECK_EN
    assign parity_ok = ^{shift_reg, parity_reg};
`else
    assign parity_ok = 1'b1;
`endif

    // The stop strobe itself is the good-frame decision, so the FIFO write lands on that same edge.
    assign good_w = strobe && (state_reg == S_STOP) && data_s && parity_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            tmo_reg      <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            if (state_reg == S_IDLE) begin
                tmo_reg <= '0;
                if (strobe) begin
                    if (!data_s) begin
                        state_reg   <= S_DATA;
                        bit_cnt_reg <= '0;
                    end else begin
                        rx_frame_err <= 1'b1;
                    end
                end
            end else if (strobe) begin
                tmo_reg <= '0;
                if (state_reg == S_DATA) begin
                    shift_reg   <= {data_s, shift_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) state_reg <= S_PARITY;
                end else if (state_reg == S_PARITY) begin
                    parity_reg <= data_s;
                    state_reg  <= S_STOP;
                end else begin
                    if (!good_w) rx_frame_err <= 1'b1;
                    state_reg <= S_IDLE;
                end
            end else if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
                rx_frame_err <= 1'b1;
                state_reg    <= S_IDLE;
                tmo_reg      <= '0;
            end else begin
                tmo_reg <= tmo_reg + 1'b1;
            end
        end
    end

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr_reg;
    logic [FIFO_AW:0] rd_ptr_reg;
    logic [HW-1:0]    hold_reg;
    logic             empty;
    logic             full;
    logic             load_w;

    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]) &&
                    (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]);
    assign load_w = !rx_data_ready && (hold_reg == '0) && !empty;

    always_ff @(posedge clk) begin
        if (good_w && !full) mem[wr_ptr_reg[FIFO_AW-1:0]] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            hold_reg      <= '0;
            rx_scan_code  <= '0;
            rx_data_ready <= 1'b0;
            rx_overflow   <= 1'b0;
        end else begin
            rx_overflow <= good_w && full;
            if (good_w && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (load_w) begin
                rx_scan_code  <= mem[rd_ptr_reg[FIFO_AW-1:0]];
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                rx_data_ready <= 1'b1;
            end else if (rx_data_ready && rx_read) begin
                rx_data_ready <= 1'b0;
                hold_reg      <= HW'(HOLD_CYC);
            end else if (hold_reg != '0) begin
                hold_reg <= hold_reg - 1'b1;
            end
        end
    end
endmodule
